// File: rtl/mult_div_unit_if.sv
// Handshake/bus bundle between the pipeline and the iterative multiply/divide unit.
// master drives the operation request and MTHI/MTLO writes; slave returns status and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: one product/quotient bit per cycle on operand
// magnitudes, signs applied in a final FIX cycle that also pulses done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [WIDTH-1:0]   upper_q, upper_d;
    logic [WIDTH-1:0]   lower_q, lower_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
    end

    // Multiply: {upper,lower} shifts right, multiplier bits leave lower while product bits enter.
    // Divide: lower holds the dividend shifting out and the quotient shifting in; upper is the remainder.
    always_comb begin
        mul_sum   = lower_q[0] ? ({1'b0, upper_q} + {1'b0, b_mag_q}) : {1'b0, upper_q};
        rem_shift = {upper_q, lower_q[WIDTH-1]};
        div_diff  = rem_shift - {1'b0, b_mag_q};
        prod      = {upper_q, lower_q};
        prod_fix  = neg_q ? -prod : prod;
        quot_fix  = neg_q ? -lower_q : lower_q;
        rem_fix   = rem_neg_q ? -upper_q : upper_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        a_d       = a_q;
        b_mag_d   = b_mag_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    is_div_d  = bus.op[1];
                    a_d       = bus.a;
                    b_mag_d   = b_mag;
                    upper_d   = '0;
                    lower_d   = a_mag;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    b_zero_d  = (bus.b == '0);
                    dz_d      = 1'b0;
                end else begin
                    if (bus.hi_we) hi_d = bus.wr_data;
                    if (bus.lo_we) lo_d = bus.wr_data;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        upper_d = div_diff[WIDTH-1:0];
                        lower_d = {lower_q[WIDTH-2:0], 1'b1};
                    end else begin
                        upper_d = rem_shift[WIDTH-1:0];
                        lower_d = {lower_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    upper_d = mul_sum[WIDTH:1];
                    lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (b_zero_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                    dz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            a_q       <= '0;
            b_mag_q   <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            a_q       <= a_d;
            b_mag_q   <= b_mag_d;
            upper_q   <= upper_d;
            lower_q   <= lower_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, randomized ops against an arithmetic model,
// and hand-written sequences for busy-time requests, MT writes and mid-operation reset.
module tb_mult_div_unit;
    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          dz;
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
    } res_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
        logic          dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: 64-bit products, truncating division, divide-by-zero rule.
    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r.dz = 1'b0;
        case (op)
            OP_MULT:  begin sp = sa * sb; r.hi = sp[63:32]; r.lo = sp[31:0]; end
            OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; r.hi = up[63:32]; r.lo = up[31:0]; end
            default: begin
                if (b == 0) begin
                    r.dz = 1'b1; r.hi = a; r.lo = '1;
                end else if (op == OP_DIV) begin
                    sq = sa / sb; sr = sa % sb;
                    r.hi = sr[31:0]; r.lo = sq[31:0];
                end else begin
                    r.hi = a % b; r.lo = a / b;
                end
            end
        endcase
        return r;
    endfunction

    // Called at a negedge; returns #1 after the Start edge with operands scrambled.
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
        check("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (bus.done) break;
        end
        check("done_seen", 64'(bus.done), 64'd1);
        check("busy_low_in_done", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        int lat;
        launch(op, a, b);
        wait_done(lat);
        check("latency", 64'(lat), 64'd33);
        check("hi", 64'(bus.hi), 64'(ehi));
        check("lo", 64'(bus.lo), 64'(elo));
        check("div_zero", 64'(bus.div_zero), 64'(edz));
        $display("op=%0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d lat=%0d", op, a, b, bus.hi, bus.lo, bus.div_zero, lat);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int   lat;
        int   done_cnt;
        res_t r;
        logic [1:0] op;
        logic [W-1:0] a, b;
        logic [W-1:0] prev_hi, prev_lo;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4] = '{OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0};
        vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[6] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[7] = '{OP_MULTU, 32'd3,        32'd3,        32'd0,        32'd9,        1'b0};
        vecs[8] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[9] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};

        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wr_data = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_dz", 64'(bus.div_zero), 0);
        check("rst_hi", 64'(bus.hi), 0);
        check("rst_lo", 64'(bus.lo), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (i % 4 == 1) a = 32'($urandom_range(0, 1000));
            r = model(op, a, b);
            run_op(op, a, b, r.hi, r.lo, r.dz);
        end

        // Start and MT writes during CALC are ignored; HI/LO hold
        prev_hi = bus.hi; prev_lo = bus.lo;
        launch(OP_MULTU, 32'd6, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1; bus.op = OP_DIVU; bus.a = 1; bus.b = 1;
        bus.hi_we = 1; bus.lo_we = 1; bus.wr_data = 32'hAA;
        @(negedge clk);
        check("hold_hi_calc", 64'(bus.hi), 64'(prev_hi));
        check("hold_lo_calc", 64'(bus.lo), 64'(prev_lo));
        bus.start = 0; bus.hi_we = 0; bus.lo_we = 0;
        wait_done(lat);
        check("busy_req_hi", 64'(bus.hi), 0);
        check("busy_req_lo", 64'(bus.lo), 64'd42);
        $display("op=%0d a=6 b=7 (busy requests) -> hi=%08h lo=%08h", OP_MULTU, bus.hi, bus.lo);

        // MT writes in IDLE
        @(negedge clk);
        bus.hi_we = 1; bus.wr_data = 32'hAA;
        @(negedge clk);
        bus.hi_we = 0;
        check("mthi", 64'(bus.hi), 64'hAA);
        check("mthi_lo_kept", 64'(bus.lo), 64'd42);
        bus.lo_we = 1; bus.wr_data = 32'h1234;
        @(negedge clk);
        bus.lo_we = 0;
        check("mtlo", 64'(bus.lo), 64'h1234);
        $display("mthi/mtlo -> hi=%08h lo=%08h", bus.hi, bus.lo);

        // Start beats a same-cycle MT write, then a back-to-back Start in the Done cycle
        bus.hi_we = 1; bus.wr_data = 32'h55;
        launch(OP_MULTU, 32'd3, 32'd5);
        wait_done(lat);
        check("start_wins_hi", 64'(bus.hi), 0);
        check("start_wins_lo", 64'(bus.lo), 64'd15);
        launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_hi", 64'(bus.hi), 64'hFFFFFFFF);
        check("b2b_lo", 64'(bus.lo), 64'hFFFFFFFD);
        $display("back-to-back div -> hi=%08h lo=%08h lat=%0d", bus.hi, bus.lo, lat);
        @(negedge clk);

        // Asynchronous reset mid-CALC
        launch(OP_MULTU, 32'hFFFF, 32'hFFFF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 0);
        check("arst_done", 64'(bus.done), 0);
        check("arst_hi", 64'(bus.hi), 0);
        check("arst_lo", 64'(bus.lo), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("no_done_after_reset", 64'(done_cnt), 0);
        $display("reset mid-op -> busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
